matrix_serializer: RTL and testbench

MATRIX_SERIALIZER -- requirements
Module: matrix_serializer

---
 rtl/matrix_serializer_if.sv | 34 +++
 rtl/matrix_serializer.sv | 86 ++++++++
 tb/tb_matrix_serializer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/matrix_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_serializer_if                                                  |
// | Load/stream handshake bundle for the matrix serializer.               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface matrix_serializer_if #(
    parameter int IN_BITS = 8,
    parameter int SIZE    = 3
);
    localparam int IDX_W = $clog2(SIZE);

    logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0] in_mat;
    logic                                   in_valid;
    logic                                   in_ready;
    logic [IN_BITS-1:0]                     out_data;
    logic [IDX_W-1:0]                       out_row;
    logic [IDX_W-1:0]                       out_col;
    logic                                   out_valid;
    logic                                   out_ready;
    logic                                   out_last;
    logic                                   done;

    modport master (
        output in_mat, in_valid, out_ready,
        input  in_ready, out_data, out_row, out_col, out_valid, out_last, done
    );

    modport slave (
        input  in_mat, in_valid, out_ready,
        output in_ready, out_data, out_row, out_col, out_valid, out_last, done
    );
endinterface
`default_nettype wire

// File: rtl/matrix_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_serializer                                                     |
// | Captures a SIZE x SIZE matrix and streams it element by element,      |
// | highest row/column first.                                             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module matrix_serializer #(
    parameter int IN_BITS = 8,
    parameter int SIZE    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    matrix_serializer_if.slave    bus
);
    localparam int                IDX_W    = $clog2(SIZE);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SIZE - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]                             state_q, state_d;
    logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0] mat_q, mat_d;
    logic [IDX_W-1:0]                       row_q, row_d;
    logic [IDX_W-1:0]                       col_q, col_d;
    logic                                   done_q, done_d;

    logic w_load;
    logic w_xfer;
    logic w_last;

    always_comb begin
        w_load  = (state_q == ST_IDLE) && bus.in_valid;
        w_xfer  = (state_q == ST_SEND) && bus.out_ready;
        w_last  = (state_q == ST_SEND) && (row_q == '0) && (col_q == '0);

        state_d = state_q;
        mat_d   = mat_q;
        row_d   = row_q;
        col_d   = col_q;
        done_d  = 1'b0;

        if (w_load) begin
            mat_d   = bus.in_mat;
            row_d   = LAST_IDX;
            col_d   = LAST_IDX;
            state_d = ST_SEND;
        end else if (w_xfer) begin
            if (w_last) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else if (col_q == '0) begin
                col_d = LAST_IDX;
                row_d = row_q - 1'b1;
            end else begin
                col_d = col_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mat_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mat_q   <= mat_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= done_d;
        end
    end

    // Data is gated so idle cycles never expose the stale last element.
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_SEND);
    assign bus.out_data  = (state_q == ST_SEND) ? mat_q[row_q][col_q] : '0;
    assign bus.out_row   = row_q;
    assign bus.out_col   = col_q;
    assign bus.out_last  = w_last;
    assign bus.done      = done_q;
endmodule
`default_nettype wire

// File: tb/tb_matrix_serializer.sv
`default_nettype none
// Directed bench: 3x3/8-bit instance plus a 2x2/4-bit instance.
module tb_matrix_serializer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    matrix_serializer_if #(.IN_BITS(8), .SIZE(3)) bus3 ();
    matrix_serializer_if #(.IN_BITS(4), .SIZE(2)) bus2 ();

    matrix_serializer #(.IN_BITS(8), .SIZE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    matrix_serializer #(.IN_BITS(4), .SIZE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic [2:0][2:0][7:0] mat_a;
    logic [2:0][2:0][7:0] mat_b;
    logic [7:0] seq_a [9];
    logic [7:0] seq_b [9];
    logic [1:0] seq_r [9];
    logic [1:0] seq_c [9];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drain a loaded 3x3 matrix at full rate, checking each element.
    task automatic drain_full(input string tag, input int which);
        for (int k = 0; k < 9; k++) begin
            check({tag, " valid"}, bus3.out_valid, 1);
            check({tag, " in_ready"}, bus3.in_ready, 0);
            check({tag, " data"}, bus3.out_data, (which == 0) ? seq_a[k] : seq_b[k]);
            check({tag, " row"}, bus3.out_row, seq_r[k]);
            check({tag, " col"}, bus3.out_col, seq_c[k]);
            check({tag, " last"}, bus3.out_last, (k == 8) ? 1 : 0);
            check({tag, " no_done"}, bus3.done, 0);
            tick();
        end
        check({tag, " done"}, bus3.done, 1);
        check({tag, " idle_valid"}, bus3.out_valid, 0);
        check({tag, " idle_ready"}, bus3.in_ready, 1);
    endtask

    initial begin
        mat_a = {{8'd1, 8'd2, 8'd3}, {8'd0, 8'd1, 8'd0}, {8'd0, 8'd0, 8'd1}};
        mat_b = {{8'h11, 8'h22, 8'h33}, {8'h44, 8'h55, 8'h66}, {8'h77, 8'h88, 8'h99}};
        seq_a = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
        seq_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        seq_r = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
        seq_c = '{2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

        bus3.in_mat = '0; bus3.in_valid = 1'b0; bus3.out_ready = 1'b0;
        bus2.in_mat = '0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;

        // Reset state, observed before any clock edge.
        #2;
        check("rst in_ready", bus3.in_ready, 1);
        check("rst out_valid", bus3.out_valid, 0);
        check("rst out_last", bus3.out_last, 0);
        check("rst done", bus3.done, 0);
        check("rst out_data", bus3.out_data, 0);
        check("rst out_row", bus3.out_row, 0);
        check("rst out_col", bus3.out_col, 0);
        tick();
        rst = 1'b1;
        tick();

        // Basic stream; in_mat overwritten right after load.
        bus3.in_mat = mat_a; bus3.in_valid = 1'b1; bus3.out_ready = 1'b1;
        tick();
        bus3.in_valid = 1'b0;
        bus3.in_mat   = {9{8'hFF}};
        drain_full("basic", 0);
        tick();
        check("basic done_pulse_end", bus3.done, 0);

        // Stalled stream: out_ready pattern 1,0,0 repeating.
        bus3.in_mat = mat_a; bus3.in_valid = 1'b1;
        tick();
        bus3.in_valid = 1'b0;
        begin
            int idx = 0;
            int cyc = 0;
            logic [7:0] prev_d;
            logic [1:0] prev_r, prev_c;
            logic       stalled = 1'b0;
            while (idx < 9 && cyc < 60) begin
                check("stall valid", bus3.out_valid, 1);
                check("stall data", bus3.out_data, seq_a[idx]);
                check("stall row", bus3.out_row, seq_r[idx]);
                check("stall col", bus3.out_col, seq_c[idx]);
                check("stall last", bus3.out_last, (idx == 8) ? 1 : 0);
                if (stalled) begin
                    check("stall hold data", bus3.out_data, prev_d);
                    check("stall hold row", bus3.out_row, prev_r);
                    check("stall hold col", bus3.out_col, prev_c);
                end
                prev_d = bus3.out_data; prev_r = bus3.out_row; prev_c = bus3.out_col;
                bus3.out_ready = (cyc % 3 == 0);
                stalled = !bus3.out_ready;
                tick();
                if (!stalled) idx++;
                cyc++;
            end
            check("stall transfers", idx, 9);
            check("stall done", bus3.done, 1);
            check("stall idle", bus3.out_valid, 0);
        end

        // in_valid held through SEND with a different matrix.
        bus3.out_ready = 1'b1; bus3.in_mat = mat_a; bus3.in_valid = 1'b1;
        tick();
        bus3.in_mat = mat_b;
        drain_full("hold", 0);
        tick();
        check("hold b_first_valid", bus3.out_valid, 1);
        bus3.in_valid = 1'b0;
        drain_full("hold_b", 1);

        // Asynchronous reset after four transfers.
        bus3.in_mat = mat_a; bus3.in_valid = 1'b1;
        tick();
        bus3.in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        check("rst_mid data5", bus3.out_data, seq_a[4]);
        #2 rst = 1'b0;
        #1;
        check("rst_mid valid", bus3.out_valid, 0);
        check("rst_mid in_ready", bus3.in_ready, 1);
        check("rst_mid data", bus3.out_data, 0);
        tick();
        #2 rst = 1'b1;
        tick();
        check("rst_mid no_done", bus3.done, 0);
        check("rst_mid no_valid", bus3.out_valid, 0);
        tick();
        check("rst_mid no_done2", bus3.done, 0);
        bus3.in_mat = mat_b; bus3.in_valid = 1'b1;
        tick();
        bus3.in_valid = 1'b0;
        drain_full("rst_reload", 1);

        // 2x2 instance with 4-bit elements.
        bus2.in_mat = {{4'hA, 4'hB}, {4'hC, 4'hD}};
        bus2.in_valid = 1'b1; bus2.out_ready = 1'b1;
        tick();
        bus2.in_valid = 1'b0;
        begin
            logic [3:0] s2_d [4];
            logic       s2_r [4];
            logic       s2_c [4];
            s2_d = '{4'hA, 4'hB, 4'hC, 4'hD};
            s2_r = '{1'b1, 1'b1, 1'b0, 1'b0};
            s2_c = '{1'b1, 1'b0, 1'b1, 1'b0};
            for (int k = 0; k < 4; k++) begin
                check("s2 valid", bus2.out_valid, 1);
                check("s2 data", bus2.out_data, s2_d[k]);
                check("s2 row", bus2.out_row, s2_r[k]);
                check("s2 col", bus2.out_col, s2_c[k]);
                check("s2 last", bus2.out_last, (k == 3) ? 1 : 0);
                tick();
            end
            check("s2 done", bus2.done, 1);
            check("s2 idle", bus2.in_ready, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
